edp_ar_regs: RTL and testbench

EBOX datapath register bank holding AR, ARX and MQ (36 bits each, PDP-10 numbering [0:35], bit 0 = MSB). It is the consumer end of the CTL register-control interface: every edge of `eboxClk` it applies CTL's load, clear and select strobes to the datapath sources and updates the three registers. Its outputs feed the adder, the shifter and `ctl` itself (`EDP_AR`).

---
 rtl/edp_ar_regs.sv | 135 +++++++++++++
 tb/tb_edp_ar_regs.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/edp_ar_regs.sv
// rtl/edp_ar_regs.sv - EBOX datapath AR/ARX/MQ register bank
// Applies CTL load/clear/select strobes each eboxClk edge; sources read pre-edge register values.
module edp_ar_regs (
    input  logic        eboxClk,
    input  logic        eboxReset,
    input  logic [0:35] CACHE_DATA,
    input  logic [0:35] EDP_AD,
    input  logic [0:35] EDP_ADX,
    input  logic [0:35] EBUS_DATA,
    input  logic [0:35] SH,
    input  logic        CTL_AR00to08load,
    input  logic        CTL_AR09to17load,
    input  logic        CTL_ARRload,
    input  logic        CTL_AR00to11clr,
    input  logic        CTL_AR12to17clr,
    input  logic        CTL_ARRclr,
    input  logic [0:2]  CTL_ARL_SEL,
    input  logic [0:2]  CTL_ARR_SEL,
    input  logic [2:0]  CTL_ARXL_SEL,
    input  logic [2:0]  CTL_ARXR_SEL,
    input  logic        CTL_ARX_LOAD,
    input  logic [0:1]  CTL_MQ_SEL,
    input  logic [0:1]  CTL_MQM_SEL,
    input  logic        CTL_MQM_EN,
    output logic [0:35] EDP_AR,
    output logic [0:35] EDP_ARX,
    output logic [0:35] EDP_MQ
);

    localparam logic [0:35] LEFT_MASK  = 36'o777777000000;
    localparam logic [0:35] RIGHT_MASK = 36'o000000777777;

    logic [0:35] ar_q, ar_d;
    logic [0:35] arx_q, arx_d;
    logic [0:35] mq_q, mq_d;

    logic [0:35] ar_cand_l, ar_cand_r, ar_src;
    logic [0:35] arx_cand_l, arx_cand_r, arx_src;
    logic [0:35] mqm;

    function automatic logic [0:35] shl2(input logic [0:35] src, input logic fill);
        return {src[1:35], fill};
    endfunction

    function automatic logic [0:35] sar25(input logic [0:35] src);
        return {src[0], src[0], src[0:33]};
    endfunction

    function automatic logic [0:35] ar_mux(input logic [0:2] sel, input logic [0:35] ar);
        logic [0:35] w;
        case (sel)
            3'd0:    w = ar;
            3'd1:    w = CACHE_DATA;
            3'd2:    w = EDP_AD;
            3'd3:    w = EBUS_DATA;
            3'd4:    w = SH;
            3'd5:    w = shl2(EDP_AD, EDP_ADX[0]);
            3'd6:    w = EDP_ADX;
            default: w = sar25(EDP_AD);
        endcase
        return w;
    endfunction

    // Select 7 is the low word of a double-word right shift: AD's low bits enter ARX at the top.
    function automatic logic [0:35] arx_mux(input logic [2:0] sel, input logic [0:35] mq);
        logic [0:35] w;
        case (sel)
            3'd0:    w = '0;
            3'd1:    w = CACHE_DATA;
            3'd2:    w = EDP_AD;
            3'd3:    w = mq;
            3'd4:    w = SH;
            3'd5:    w = shl2(EDP_ADX, mq[0]);
            3'd6:    w = EDP_ADX;
            default: w = {EDP_AD[34:35], EDP_ADX[0:33]};
        endcase
        return w;
    endfunction

    always_comb begin
        ar_cand_l = ar_mux(CTL_ARL_SEL, ar_q);
        ar_cand_r = ar_mux(CTL_ARR_SEL, ar_q);
        ar_src    = (ar_cand_l & LEFT_MASK) | (ar_cand_r & RIGHT_MASK);

        ar_d = ar_q;
        if (CTL_AR00to08load) ar_d[0:8]   = ar_src[0:8];
        if (CTL_AR09to17load) ar_d[9:17]  = ar_src[9:17];
        if (CTL_ARRload)      ar_d[18:35] = ar_src[18:35];
        if (CTL_AR00to11clr)  ar_d[0:11]  = '0;
        if (CTL_AR12to17clr)  ar_d[12:17] = '0;
        if (CTL_ARRclr)       ar_d[18:35] = '0;
    end

    always_comb begin
        arx_cand_l = arx_mux(CTL_ARXL_SEL, mq_q);
        arx_cand_r = arx_mux(CTL_ARXR_SEL, mq_q);
        arx_src    = (arx_cand_l & LEFT_MASK) | (arx_cand_r & RIGHT_MASK);
        arx_d      = CTL_ARX_LOAD ? arx_src : arx_q;
    end

    always_comb begin
        mqm = '0;
        if (CTL_MQM_EN) begin
            case (CTL_MQM_SEL)
                2'd0:    mqm = {EDP_ADX[34:35], mq_q[0:33]};
                2'd1:    mqm = SH;
                2'd2:    mqm = shl2(mq_q, 1'b0);
                default: mqm = '1;
            endcase
        end
        case (CTL_MQ_SEL)
            2'd0:    mq_d = mq_q;
            2'd1:    mq_d = SH;
            2'd2:    mq_d = mqm;
            default: mq_d = EDP_AD;
        endcase
    end

    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            ar_q  <= '0;
            arx_q <= '0;
            mq_q  <= '0;
        end else begin
            ar_q  <= ar_d;
            arx_q <= arx_d;
            mq_q  <= mq_d;
        end
    end

    assign EDP_AR  = ar_q;
    assign EDP_ARX = arx_q;
    assign EDP_MQ  = mq_q;

endmodule

// File: tb/tb_edp_ar_regs.sv
// tb/tb_edp_ar_regs.sv - directed scoreboard bench for edp_ar_regs
module tb_edp_ar_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:35] cache_data, edp_ad, edp_adx, ebus_data, sh;
    logic        ar0_ld, ar9_ld, arr_ld, ar0_clr, ar12_clr, arr_clr;
    logic [0:2]  arl_sel, arr_sel;
    logic [2:0]  arxl_sel, arxr_sel;
    logic        arx_load;
    logic [0:1]  mq_sel, mqm_sel;
    logic        mqm_en;
    logic [0:35] edp_ar, edp_arx, edp_mq;

    typedef struct {
        string       tag;
        logic [0:35] ar;
        logic [0:35] arx;
        logic [0:35] mq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [0:35] ONES = 36'o777777777777;

    edp_ar_regs dut (
        .eboxClk          (clk),
        .eboxReset        (rst),
        .CACHE_DATA       (cache_data),
        .EDP_AD           (edp_ad),
        .EDP_ADX          (edp_adx),
        .EBUS_DATA        (ebus_data),
        .SH               (sh),
        .CTL_AR00to08load (ar0_ld),
        .CTL_AR09to17load (ar9_ld),
        .CTL_ARRload      (arr_ld),
        .CTL_AR00to11clr  (ar0_clr),
        .CTL_AR12to17clr  (ar12_clr),
        .CTL_ARRclr       (arr_clr),
        .CTL_ARL_SEL      (arl_sel),
        .CTL_ARR_SEL      (arr_sel),
        .CTL_ARXL_SEL     (arxl_sel),
        .CTL_ARXR_SEL     (arxr_sel),
        .CTL_ARX_LOAD     (arx_load),
        .CTL_MQ_SEL       (mq_sel),
        .CTL_MQM_SEL      (mqm_sel),
        .CTL_MQM_EN       (mqm_en),
        .EDP_AR           (edp_ar),
        .EDP_ARX          (edp_arx),
        .EDP_MQ           (edp_mq)
    );

    always #5 clk = ~clk;

    task automatic idle_ctl();
        rst = 1'b0;
        cache_data = '0; edp_ad = '0; edp_adx = '0; ebus_data = '0; sh = '0;
        ar0_ld = 1'b0; ar9_ld = 1'b0; arr_ld = 1'b0;
        ar0_clr = 1'b0; ar12_clr = 1'b0; arr_clr = 1'b0;
        arl_sel = 3'd0; arr_sel = 3'd0; arxl_sel = 3'd0; arxr_sel = 3'd0;
        arx_load = 1'b0; mq_sel = 2'd0; mqm_sel = 2'd0; mqm_en = 1'b0;
    endtask

    task automatic check_word(input string tag, input string fld,
                              input logic [0:35] obs, input logic [0:35] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s.%s observed %o expected %o", tag, fld, obs, exp);
        end
    endtask

    // Push the expectation, clock the step, then pop and compare after the edge.
    task automatic step(input string tag, input logic [0:35] ar,
                        input logic [0:35] arx, input logic [0:35] mq);
        exp_t e;
        e.tag = tag; e.ar = ar; e.arx = arx; e.mq = mq;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_word(e.tag, "ar", edp_ar, e.ar);
        check_word(e.tag, "arx", edp_arx, e.arx);
        check_word(e.tag, "mq", edp_mq, e.mq);
        idle_ctl();
    endtask

    task automatic preload_ones();
        cache_data = ONES; sh = ONES;
        ar0_ld = 1'b1; ar9_ld = 1'b1; arr_ld = 1'b1;
        arl_sel = 3'd1; arr_sel = 3'd1;
        arxl_sel = 3'd1; arxr_sel = 3'd1; arx_load = 1'b1;
        mq_sel = 2'd1;
    endtask

    initial begin
        idle_ctl();
        @(negedge clk);

        rst = 1'b1;
        step("reset_init", '0, '0, '0);

        preload_ones();
        step("preload", ONES, ONES, ONES);

        step("idle_hold", ONES, ONES, ONES);

        preload_ones();
        ar0_clr = 1'b1; ar12_clr = 1'b1; arr_clr = 1'b0;
        mqm_en = 1'b1; mqm_sel = 2'd3;
        rst = 1'b1;
        step("reset_over_loads", '0, '0, '0);

        edp_ad = 36'o123456701234; cache_data = 36'o000000555555;
        arl_sel = 3'd2; arr_sel = 3'd1;
        ar0_ld = 1'b1; ar9_ld = 1'b0; arr_ld = 1'b1;
        step("split_load", 36'o123000555555, '0, '0);

        cache_data = ONES; arl_sel = 3'd1; arr_sel = 3'd1;
        ar0_ld = 1'b1; ar9_ld = 1'b1; arr_ld = 1'b1;
        step("ar_ones", ONES, '0, '0);

        edp_ad = 36'o525252525252; arl_sel = 3'd2;
        ar0_clr = 1'b1; ar0_ld = 1'b1; ar9_ld = 1'b1;
        step("clr_vs_load", 36'o000052777777, '0, '0);

        edp_ad = 36'o400000000001; edp_adx = 36'o400000000000;
        arl_sel = 3'd5; arr_sel = 3'd5;
        ar0_ld = 1'b1; ar9_ld = 1'b1; arr_ld = 1'b1;
        step("ar_x2", 36'o000000000003, '0, '0);

        edp_ad = 36'o400000000001;
        arl_sel = 3'd7; arr_sel = 3'd7;
        ar0_ld = 1'b1; ar9_ld = 1'b1; arr_ld = 1'b1;
        step("ar_x025", 36'o700000000000, '0, '0);

        edp_ad = 36'o000000000010; mq_sel = 2'd3;
        step("mq_from_ad", 36'o700000000000, '0, 36'o000000000010);

        edp_adx = 36'o000000000004; edp_ad = 36'o000000000003;
        arxl_sel = 3'd7; arxr_sel = 3'd7; arx_load = 1'b1;
        mq_sel = 2'd2; mqm_en = 1'b1; mqm_sel = 2'd0;
        step("double_shift", 36'o700000000000, 36'o600000000001, 36'o000000000002);

        sh = 36'o111111111111; mq_sel = 2'd1;
        step("mq_from_sh", 36'o700000000000, 36'o600000000001, 36'o111111111111);

        arxl_sel = 3'd3; arxr_sel = 3'd3; arx_load = 1'b1;
        mq_sel = 2'd3; edp_ad = 36'o222222222222;
        step("same_cycle_read", 36'o700000000000, 36'o111111111111, 36'o222222222222);

        mqm_en = 1'b0; mqm_sel = 2'd3; mq_sel = 2'd2;
        step("mqm_disabled", 36'o700000000000, 36'o111111111111, '0);

        cache_data = ONES; arl_sel = 3'd1; arr_sel = 3'd1;
        ar0_ld = 1'b1; ar9_ld = 1'b1; arr_ld = 1'b1;
        ar12_clr = 1'b1; arr_clr = 1'b1;
        mqm_en = 1'b1; mqm_sel = 2'd3; mq_sel = 2'd2;
        step("partial_clr_mqm_ones", 36'o777700000000, 36'o111111111111, ONES);

        edp_adx = 36'o200000000001;
        arxl_sel = 3'd6; arxr_sel = 3'd5; arx_load = 1'b1;
        mqm_en = 1'b1; mqm_sel = 2'd2; mq_sel = 2'd2;
        step("arx_halves_mq_x2", 36'o777700000000, 36'o200000000003, 36'o777777777776);

        preload_ones();
        rst = 1'b1;
        step("reset_mid", '0, '0, '0);

        sh = 36'o000000000123; mq_sel = 2'd1;
        step("post_reset", '0, '0, 36'o000000000123);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
